bcd_to_bin2c_seq: RTL
=====================

# bcd_to_bin2c_seq

Sequential, parametrised BCD-to-two's-complement converter for the calculator datapath. It sits between the keypad/digit-entry logic and the ALU. It converts DIGITS packed BCD digits plus a sign flag into a WIDTH-bit two's-complement operand, using iterative reverse double-dabble with one shift per cycle. Beyond a plain combinational converter, it adds a valid/ready handshake on both sides, invalid-digit detection, and saturation with a range flag when the signed result does not fit in WIDTH.

## Interface
- DIGITS, default 3: number of BCD digits (1..8).
- WIDTH, default 10: output width in bits, two's complement (2..32).
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request; bcds and negative are valid.
- in_ready  out  1  block can accept a request (state IDLE).
- bcds  in  4*DIGITS  packed BCD; digit k is bcds[4k+3:4k], digit 0 least significant.
- negative  in  1  sign of the entered value.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- bin2c  out  WIDTH  two's-complement result.
- err_digit  out  1  some input digit was >9.
- err_range  out  1  value was saturated.

## Operation
- FSM states: IDLE, CONV, FINAL, HOLD.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: load bcd_reg←bcds, mag_reg (4*DIGITS bits)←0, neg_reg←negative, cnt←4*DIGITS-1.
  - At the same edge, latch dig_err←(any digit >9). Go to CONV.
- CONV: each cycle, shift {bcd_reg,mag_reg} right by 1. Then, in each 4-bit digit of the shifted bcd_reg, any value ≥8 is reduced by 3. Decrement cnt; leave after the cycle where cnt==0 (exactly 4*DIGITS cycles). Go to FINAL.
- FINAL: compute the registered outputs, then go to HOLD with out_valid=1.
  - If dig_err: bin2c=0, err_digit=1, err_range=0.
  - Else if !neg_reg and mag>2^(WIDTH-1)-1: bin2c=2^(WIDTH-1)-1, err_range=1.
  - Else if neg_reg and mag>2^(WIDTH-1): bin2c=-2^(WIDTH-1), err_range=1.
  - Else bin2c = neg_reg ? (~mag+1) truncated to WIDTH : mag.
  - Negative zero yields 0 with no flag.
- HOLD: outputs stable while out_ready=0. On out_ready, clear out_valid and go to IDLE.
- Comparisons use max(4*DIGITS, WIDTH+1) bits, so no truncation occurs before the range check.
- in_valid is ignored outside IDLE; inputs are sampled only at acceptance.

## Timing
- Reset, asynchronous: state=IDLE, out_valid=0, bin2c=0, err_digit=0, err_range=0, internal registers 0.
  - in_ready reads 1 during and after reset.
  - Reset mid-CONV/FINAL/HOLD aborts the conversion; no out_valid pulse follows.
- Latency: acceptance edge T0; out_valid rises at edge T0+4*DIGITS+1, i.e. 13 edges for DIGITS=3.
- Throughput: with out_ready tied high, HOLD lasts 1 cycle and the next request is accepted 1 cycle after. That gives one result per 4*DIGITS+3 cycles.
- bin2c, err_digit and err_range change only at the FINAL→HOLD edge and are stable throughout HOLD.
- Error cases keep the same latency as normal conversions.

## Structure
- Package bcd_conv_pkg:
  - state enum type (IDLE, CONV, FINAL, HOLD).
  - function cnt_bits(DIGITS) sizing the iteration counter.
  - function sat_pos(WIDTH) and function sat_neg(WIDTH).
- Sub-module bcd_digit_adj: combinational 4-bit "if ≥8 subtract 3". Instantiate DIGITS copies via generate.
- Top holds the FSM, counter, shift registers and output saturation/negation.

## Test plan
- DIGITS=3, WIDTH=10, bcds=0x123, negative=0 -> bin2c=10'h07B, no flags, out_valid 13 edges after acceptance.
- bcds=0x123, negative=1 -> bin2c=10'h385. bcds=0x000, negative=1 -> bin2c=0, no flags.
- bcds=0x512, negative=0 -> bin2c=10'h1FF, err_range=1. bcds=0x512, negative=1 -> 10'h200, err_range=0. bcds=0x999, negative=1 -> 10'h200, err_range=1.
- bcds=0x1A3 -> err_digit=1, bin2c=0, err_range=0, same 13-edge latency.
- out_ready held low 5 cycles in HOLD -> outputs stable, in_ready=0, second in_valid ignored. out_ready high -> in_ready=1 next cycle.
- rst_n asserted 4 cycles into CONV -> all outputs 0 immediately, no out_valid. New request 0x042 after release -> 10'h02A.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared types and sizing helpers for the sequential BCD converter.
// Provides the FSM state type, counter sizing and saturation limits.
package bcd_conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      FINAL,
      HOLD
   } state_t;

   // Bits needed to count 4*digits-1 down to zero.
   function automatic int cnt_bits(input int digits);
      return (4 * digits <= 2) ? 1 : $clog2(4 * digits);
   endfunction

   // Largest positive value: 2^(width-1)-1.
   function automatic logic [63:0] sat_pos(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   // Magnitude of the most negative value, 2^(width-1); truncated to
   // width bits it is also the two's-complement pattern of -2^(width-1).
   function automatic logic [63:0] sat_neg(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble.
// Ports: digit (4b in), adj (4b out) = digit>=8 ? digit-3 : digit.
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   always_comb begin
      adj = digit;
      if (digit >= 4'd8) adj = digit - 4'd3;
   end

endmodule

// File: rtl/bcd_to_bin2c_seq.sv
// Iterative BCD to two's-complement converter with saturation.
// Ports: clk, rst_n, in_valid/in_ready/bcds/negative (request side),
// out_valid/out_ready/bin2c/err_digit/err_range (result side).
module bcd_to_bin2c_seq
   import bcd_conv_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int WIDTH  = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] bcds,
   input  logic                negative,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    bin2c,
   output logic                err_digit,
   output logic                err_range
);

   localparam int NB = 4 * DIGITS;
   localparam int CB = cnt_bits(DIGITS);
   // Wide enough that neither magnitude nor limits truncate.
   localparam int XW = (NB > WIDTH + 1) ? NB : WIDTH + 1;

   localparam logic [XW-1:0] POS_LIM  = XW'(sat_pos(WIDTH));
   localparam logic [XW-1:0] NEG_LIM  = XW'(sat_neg(WIDTH));
   localparam logic [CB-1:0] CNT_INIT = CB'(NB - 1);

   state_t          state;
   state_t          state_nx;
   logic [NB-1:0]   bcd_reg;
   logic [NB-1:0]   mag_reg;
   logic [NB-1:0]   bcd_sh;
   logic [NB-1:0]   bcd_adj;
   logic [CB-1:0]   cnt;
   logic            neg_reg;
   logic            dig_err;
   logic            dig_bad;
   logic            accept;
   logic [XW-1:0]   mag_x;
   logic [WIDTH-1:0] res;
   logic            res_rng;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid) state_nx = CONV;
         CONV:    if (cnt == '0) state_nx = FINAL;
         FINAL:   state_nx = HOLD;
         HOLD:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == HOLD);
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      dig_bad = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcds[4*k +: 4] > 4'd9) dig_bad = 1'b1;
      end
   end

   // BCD half of the right shift; its LSB feeds the magnitude MSB.
   assign bcd_sh = bcd_reg >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit (bcd_sh[4*g +: 4]),
         .adj   (bcd_adj[4*g +: 4])
      );
   end

   // Saturation and negation on the finished magnitude
   always_comb begin
      mag_x   = XW'(mag_reg);
      res     = '0;
      res_rng = 1'b0;
      if (dig_err) begin
         res = '0;
      end else if (!neg_reg && mag_x > POS_LIM) begin
         res     = WIDTH'(POS_LIM);
         res_rng = 1'b1;
      end else if (neg_reg && mag_x > NEG_LIM) begin
         res     = WIDTH'(NEG_LIM);
         res_rng = 1'b1;
      end else if (neg_reg) begin
         res = WIDTH'(~mag_x + XW'(1));
      end else begin
         res = WIDTH'(mag_x);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_reg   <= '0;
         mag_reg   <= '0;
         cnt       <= '0;
         neg_reg   <= 1'b0;
         dig_err   <= 1'b0;
         bin2c     <= '0;
         err_digit <= 1'b0;
         err_range <= 1'b0;
      end else if (accept) begin
         bcd_reg <= bcds;
         mag_reg <= '0;
         cnt     <= CNT_INIT;
         neg_reg <= negative;
         dig_err <= dig_bad;
      end else if (state == CONV) begin
         bcd_reg <= bcd_adj;
         mag_reg <= {bcd_reg[0], mag_reg[NB-1:1]};
         cnt     <= cnt - CB'(1);
      end else if (state == FINAL) begin
         bin2c     <= res;
         err_digit <= dig_err;
         err_range <= res_rng;
      end
   end

endmodule
